// File: rtl/data_mem_responder.sv
// Memory-side responder for the pipelined processor data port: combinational
// loads, synchronous stores, a post-reset clear sweep, debug read and access statistics.
module data_mem_responder #(
    parameter int DataWidth = 16,
    parameter int AddrBits  = 8,
    parameter int CntWidth  = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 MemRead,
    input  logic                 MemWrite,
    input  logic [DataWidth-1:0] MemAddr,
    input  logic [DataWidth-1:0] MemData,
    output logic [DataWidth-1:0] MemOutput,
    input  logic [AddrBits-1:0]  dbg_addr,
    output logic [DataWidth-1:0] dbg_value,
    output logic                 Busy,
    output logic                 Fault,
    output logic [CntWidth-1:0]  ReadCount,
    output logic [CntWidth-1:0]  WriteCount
);

    localparam int Depth = 2 ** AddrBits;
    localparam logic [AddrBits-1:0] PtrOne  = {{(AddrBits-1){1'b0}}, 1'b1};
    localparam logic [AddrBits-1:0] PtrLast = {AddrBits{1'b1}};
    localparam logic [CntWidth-1:0] CntOne  = {{(CntWidth-1){1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] CntMax  = {CntWidth{1'b1}};

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t                 r_state;
    logic [AddrBits-1:0]    r_clr_ptr;
    logic [DataWidth-1:0]   r_mem [Depth];
    logic                   r_fault;
    logic [CntWidth-1:0]    r_read_cnt;
    logic [CntWidth-1:0]    r_write_cnt;

    logic [AddrBits-1:0]    w_word_addr;
    logic                   w_oor;
    logic                   w_ready;
    logic                   w_rd_ok;
    logic                   w_wr_ok;

    assign w_word_addr = MemAddr[AddrBits-1:0];

    // Upper address bits beyond the implemented depth flag an out-of-range access.
    generate
        if (AddrBits == DataWidth) begin : g_full_addr
            assign w_oor = 1'b0;
        end else begin : g_part_addr
            assign w_oor = |MemAddr[DataWidth-1:AddrBits];
        end
    endgenerate

    assign w_ready = (r_state == ST_READY);
    assign w_rd_ok = w_ready & MemRead  & ~w_oor;
    assign w_wr_ok = w_ready & MemWrite & ~w_oor;

    // Sweep/ready state machine, sticky fault flag and saturating access counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_CLEAR;
            r_clr_ptr   <= {AddrBits{1'b0}};
            r_fault     <= 1'b0;
            r_read_cnt  <= {CntWidth{1'b0}};
            r_write_cnt <= {CntWidth{1'b0}};
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + PtrOne;
                    if (r_clr_ptr == PtrLast) begin
                        r_state <= ST_READY;
                    end else begin
                        r_state <= ST_CLEAR;
                    end
                end
                ST_READY: r_state <= ST_READY;
                default:  r_state <= ST_CLEAR;
            endcase

            if ((MemRead | MemWrite) & w_oor) begin
                r_fault <= 1'b1;
            end

            if (w_rd_ok && (r_read_cnt != CntMax)) begin
                r_read_cnt <= r_read_cnt + CntOne;
            end

            if (w_wr_ok && (r_write_cnt != CntMax)) begin
                r_write_cnt <= r_write_cnt + CntOne;
            end
        end
    end

    // Storage array: the sweep owns the write port until the memory is ready.
    always_ff @(posedge CLK) begin
        if (!RST && (r_state == ST_CLEAR)) begin
            r_mem[r_clr_ptr] <= {DataWidth{1'b0}};
        end else if (!RST && w_wr_ok) begin
            r_mem[w_word_addr] <= MemData;
        end
    end

    // Zero-latency read paths, forced to zero while the sweep is running.
    always_comb begin
        MemOutput = {DataWidth{1'b0}};
        dbg_value = {DataWidth{1'b0}};
        if (w_rd_ok) begin
            MemOutput = r_mem[w_word_addr];
        end else begin
            MemOutput = {DataWidth{1'b0}};
        end
        if (w_ready) begin
            dbg_value = r_mem[dbg_addr];
        end else begin
            dbg_value = {DataWidth{1'b0}};
        end
    end

    assign Busy       = ~w_ready;
    assign Fault      = r_fault;
    assign ReadCount  = r_read_cnt;
    assign WriteCount = r_write_cnt;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder: the memory-side end of the Pipelined_Processor data port (MemRead, MemWrite, MemAddr, MemData, MemOutput).
- Replaces the constant MemOutput driver in top-level benches, so LW/SW programs run against real storage.
- Provides combinational read, synchronous write, and a reset-time clear sweep.
- Provides a debug read port, access counters and a sticky out-of-range fault flag.

Parameters:
DataWidth, 16, width of data word and of MemAddr
AddrBits, 8, implemented word-address bits; depth = 2**AddrBits words
CntWidth, 16, width of read/write access counters

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  synchronous, active-high reset
MemRead  input  1  processor load request (MEM stage)
MemWrite  input  1  processor store request (MEM stage)
MemAddr  input  DataWidth  word address from processor
MemData  input  DataWidth  store data from processor
MemOutput  output  DataWidth  load data to processor
dbg_addr  input  AddrBits  debug read address
dbg_value  output  DataWidth  mem[dbg_addr], combinational
Busy  output  1  high while clear sweep in progress
Fault  output  1  sticky out-of-range access flag
ReadCount  output  CntWidth  accepted loads since reset
WriteCount  output  CntWidth  accepted stores since reset

Behaviour:
- Addressing:
  - word address = MemAddr[AddrBits-1:0].
  - Access is out-of-range if any MemAddr[DataWidth-1:AddrBits] bit is 1.
  - If AddrBits == DataWidth, no address is out-of-range.
- FSM states:
  - CLEAR: entered on any cycle with RST=1, regardless of current state, including mid-sweep; sweep restarts at 0.
    - Each cycle in CLEAR writes 0 to mem[clr_ptr] and increments clr_ptr.
    - When clr_ptr == 2**AddrBits-1 is written, next state is READY.
    - Sweep takes exactly 2**AddrBits cycles after RST deasserts.
  - READY: normal service.
- Reset values (cycle after RST sampled high): clr_ptr=0, Busy=1, Fault=0, ReadCount=0, WriteCount=0.
- Busy = (state==CLEAR).
- While Busy:
  - MemWrite ignored; counters unchanged.
  - MemOutput=0; dbg_value=0.
  - Fault still updates on out-of-range MemRead/MemWrite.
- READY, read:
  - MemOutput = MemRead ? mem[word address] : 0. Combinational, zero latency.
  - Out-of-range reads return 0.
  - ReadCount increments on each edge with MemRead=1, in-range and not Busy.
- READY, write:
  - On an edge with MemWrite=1 and in-range, mem[word address] <= MemData; WriteCount increments.
  - New data is visible on MemOutput/dbg_value immediately after that edge.
  - Out-of-range writes are suppressed (memory unchanged).
- Simultaneous MemRead and MemWrite:
  - Store performed.
  - MemOutput in that cycle shows pre-write contents.
  - Both counters increment.
  - Fault set if out-of-range.
- Fault:
  - Set on the edge after any MemRead or MemWrite with out-of-range address.
  - Held until RST.
- Counters saturate at all-ones (no wrap).
- dbg_value = mem[dbg_addr] when READY; independent of MemRead.

Test Plan:
- RST=1 for 1 cycle, then 0; DataWidth=16, AddrBits=8 -> Busy=1 for exactly 256 cycles then 0; dbg_value=0x0000 for every dbg_addr 0..255; counters 0, Fault=0.
- READY; MemWrite=1, MemAddr=0x0005, MemData=0xFFEA for one cycle; then MemRead=1, MemAddr=0x0005 -> MemOutput=0xFFEA same cycle; dbg_addr=5 -> dbg_value=0xFFEA; WriteCount=1, ReadCount=1 after the read edge.
- MemRead=1 and MemWrite=1, MemAddr=0x0003, old mem[3]=0x0003, MemData=0x0004 -> MemOutput=0x0003 before edge, 0x0004 after edge; both counters +1.
- MemWrite=1, MemAddr=0x0105, MemData=0x1234 -> Fault=1 next cycle; mem[5] unchanged (0xFFEA); WriteCount unchanged; Fault still 1 ten cycles later.
- MemWrite=1, MemAddr=0x0010, MemData=0xBEEF during Busy (cycle 20 of sweep) -> after sweep, mem[0x10]=0x0000, WriteCount=0.
- Assert RST at sweep cycle 100 for one cycle -> Busy stays high; sweep restarts; Busy falls exactly 256 cycles after RST deassertion.
